mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, word address width (512-word RAM).
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter VGA_MAX_WAIT, default 4, maximum cycles a pending VGA request may be denied before it is forced.
REQ-004 sysclk  in  1  single clock; all state changes on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  CPU access request; held with address/data until cpu_gnt.
REQ-007 cpu_we  in  1  CPU write (1) / read (0).
REQ-008 cpu_addr  in  ADDR_W  CPU word address.
REQ-009 cpu_wdata  in  DATA_W  CPU write data.
REQ-010 cpu_gnt  out  1  CPU access performed this cycle.
REQ-011 cpu_rvalid  out  1  CPU read data valid (one cycle after read grant).
REQ-012 cpu_rdata  out  DATA_W  CPU read data.
REQ-013 vga_req  in  1  VGA read request; held with address until vga_gnt.
REQ-014 vga_addr  in  ADDR_W  VGA word address.
REQ-015 vga_gnt  out  1  VGA access performed this cycle.
REQ-016 vga_rvalid  out  1  VGA read data valid (one cycle after grant).
REQ-017 vga_rdata  out  DATA_W  VGA read data.
REQ-018 mem_en, mem_we  out  1 each  RAM port enable and write enable.
REQ-019 mem_addr  out  ADDR_W, mem_wdata  out  DATA_W  RAM address and write data.
REQ-020 mem_rdata  in  DATA_W  RAM synchronous read data, valid the cycle after mem_en with mem_we=0.

Function
REQ-021 At most one of cpu_gnt/vga_gnt is high per cycle; each gnt is combinational from the current requests and registered arbitration state.
REQ-022 Granted requester drives mem_addr/mem_we/mem_wdata in the grant cycle with mem_en=1; no grant -> mem_en=0, mem_we=0.
REQ-023 VGA grants always have mem_we=0.
REQ-024 Read grant in cycle N -> matching rvalid=1 in cycle N+1 with rdata=mem_rdata; rvalid low otherwise; write grants produce no rvalid.
REQ-025 cpu_rdata/vga_rdata hold last valid value while their rvalid is low.
REQ-026 Single request -> granted the same cycle, zero wait.
REQ-027 Both requesting -> winner by policy (REQ-034/035) unless starvation override (REQ-028).
REQ-028 Saturating counter vga_wait increments each cycle vga_req=1 and vga_gnt=0; clears on vga_gnt or vga_req=0; when vga_wait >= VGA_MAX_WAIT, VGA wins unconditionally.
REQ-029 Registered last_winner (CPU/VGA) updates only on a grant.
REQ-030 Requests dropped before grant are legal; no state other than vga_wait changes.

Reset
REQ-031 reset_n low: gnt, rvalid, mem_en, mem_we = 0; rdata outputs = 0; vga_wait = 0; last_winner = VGA.
REQ-032 Reset asserted mid-access cancels the pending rvalid; first cycle after release arbitrates afresh.

Configuration
REQ-033 Macro MEM_ARBITER_RR_EN selects the conflict policy.
REQ-034 Defined: round-robin; on conflict the requester that is not last_winner wins.
REQ-035 Undefined: fixed priority; CPU wins on conflict, VGA served only by idle CPU or REQ-028 override.

Structure
REQ-036 Package mem_arbiter_pkg holds typedef requester_t (REQ_CPU, REQ_VGA) and default parameter constants.
REQ-037 No sub-module; arbitration, wait counter and rvalid pipeline in one module.

Verification
REQ-038 CPU-only read addr 0x010, RAM[0x10]=0x12345678 -> cpu_gnt same cycle, next cycle cpu_rvalid=1, cpu_rdata=0x12345678.
REQ-039 CPU write addr 0x041 data 0xA5A5A5A5 -> mem_we=1, mem_addr=0x041, cpu_gnt=1, no rvalid; later VGA read 0x041 returns 0xA5A5A5A5.
REQ-040 Both request continuously, RR_EN defined -> grants alternate CPU/VGA each cycle, starting with CPU after reset.
REQ-041 Both request continuously, RR_EN undefined, VGA_MAX_WAIT=4 -> CPU granted 4 cycles, VGA forced on 5th, pattern repeats.
REQ-042 reset_n pulsed low the cycle after a VGA read grant -> vga_rvalid stays 0, all outputs 0 while low.
REQ-043 Idle cycle (no requests) -> mem_en=0, both gnt=0, vga_wait remains 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types and default sizing.
// Round-robin conflict policy is enabled by MEM_ARBITER_RR_EN.
package mem_arbiter_pkg;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_VGA = 1'b1
  } requester_t;

  localparam int ADDR_W_DEF       = 9;
  localparam int DATA_W_DEF       = 32;
  localparam int VGA_MAX_WAIT_DEF = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU/VGA request bus and single-port RAM bus seen by mem_arbiter.
// slave: arbiter side; master: requesters plus RAM side.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  vga_req, vga_addr,
    output vga_gnt, vga_rvalid, vga_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output vga_req, vga_addr,
    input  vga_gnt, vga_rvalid, vga_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// CPU/VGA single-port RAM arbiter with VGA starvation override.
// MEM_ARBITER_RR_EN: round-robin on conflict; else CPU priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int VGA_MAX_WAIT = VGA_MAX_WAIT_DEF
) (
  input logic          sysclk,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);

  localparam int WAIT_W =
    (VGA_MAX_WAIT < 1) ? 1 : $clog2(VGA_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX =
    WAIT_W'(VGA_MAX_WAIT);

  logic [WAIT_W-1:0] vga_wait;
  requester_t        last_winner;
  logic              cpu_rd_q;
  logic              vga_rd_q;
  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] vga_hold;

  logic vga_force;
  logic rr_vga;
  logic cpu_win;
  logic vga_win;

`ifndef MEM_ARBITER_RR_EN
  logic unused_last;
  assign unused_last = (last_winner == REQ_VGA);
`endif

  always_comb begin
    vga_force = bus.vga_req & (vga_wait >= WAIT_MAX);
`ifdef MEM_ARBITER_RR_EN
    rr_vga = (last_winner == REQ_CPU);
`else
    rr_vga = 1'b0;
`endif
    // Reset gates grants so the RAM port is idle while held.
    vga_win = reset_n & bus.vga_req
            & (~bus.cpu_req | vga_force | rr_vga);
    cpu_win = reset_n & bus.cpu_req & ~vga_win;
  end

  assign bus.cpu_gnt   = cpu_win;
  assign bus.vga_gnt   = vga_win;
  assign bus.mem_en    = cpu_win | vga_win;
  assign bus.mem_we    = cpu_win & bus.cpu_we;
  assign bus.mem_addr  = cpu_win ? bus.cpu_addr :
                         vga_win ? bus.vga_addr : '0;
  assign bus.mem_wdata = bus.mem_we ? bus.cpu_wdata : '0;

  assign bus.cpu_rvalid = cpu_rd_q;
  assign bus.vga_rvalid = vga_rd_q;
  assign bus.cpu_rdata  = cpu_rd_q ? bus.mem_rdata : cpu_hold;
  assign bus.vga_rdata  = vga_rd_q ? bus.mem_rdata : vga_hold;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      vga_wait    <= '0;
      last_winner <= REQ_VGA;
      cpu_rd_q    <= 1'b0;
      vga_rd_q    <= 1'b0;
      cpu_hold    <= '0;
      vga_hold    <= '0;
    end else begin
      cpu_rd_q <= cpu_win & ~bus.cpu_we;
      vga_rd_q <= vga_win;
      if (cpu_rd_q) cpu_hold <= bus.mem_rdata;
      if (vga_rd_q) vga_hold <= bus.mem_rdata;
      if (cpu_win)      last_winner <= REQ_CPU;
      else if (vga_win) last_winner <= REQ_VGA;
      if (bus.vga_req & ~vga_win) begin
        if (vga_wait != WAIT_MAX)
          vga_wait <= vga_wait + 1'b1;
      end else begin
        vga_wait <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, policy
// sequences, reset corner and randomized traffic vs. a model.
module tb_mem_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int MW = 4;

  logic sysclk  = 1'b0;
  logic reset_n = 1'b0;
  always #5 sysclk = ~sysclk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .VGA_MAX_WAIT(MW)
  ) dut (
    .sysclk (sysclk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 16) return 32'h1234_5678;
    return 32'h1000_0000 + i * 32'h0001_0001;
  endfunction

  // RAM environment: synchronous read, write-first not needed
  logic [DW-1:0] ram [0:511];
  bit ram_ready = 1'b0;
  always @(posedge sysclk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 512; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] ref_mem [0:511];
  int            m_wait;
  bit            m_last_vga;
  bit            m_cpend, m_vpend;
  logic [DW-1:0] m_cdata, m_vdata, m_chold, m_vhold;
  bit            e_cg, e_vg;

  typedef struct {
    bit          cr;
    bit          cwe;
    logic [8:0]  ca;
    logic [31:0] cd;
    bit          vr;
    logic [8:0]  va;
    bit          ecg;
    bit          evg;
    bit          ecv;
    logic [31:0] ecd;
    bit          evv;
    logic [31:0] evd;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit cr, input bit cwe,
                       input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd,
                       input bit vr,
                       input logic [AW-1:0] va);
    bus.cpu_req   = cr;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.vga_req   = vr;
    bus.vga_addr  = va;
  endtask

  task automatic model_reset();
    m_wait     = 0;
    m_last_vga = 1'b1;
    m_cpend    = 1'b0;
    m_vpend    = 1'b0;
    m_chold    = '0;
    m_vhold    = '0;
    m_cdata    = '0;
    m_vdata    = '0;
  endtask

  // Predict this cycle's grants from the rules, then compare at negedge
  task automatic eval_check();
    bit cr, vr, pick_vga;
    cr = bus.cpu_req;
    vr = bus.vga_req;
`ifdef MEM_ARBITER_RR_EN
    pick_vga = !m_last_vga;
`else
    pick_vga = 1'b0;
`endif
    e_vg = vr && (!cr || m_wait >= MW || pick_vga);
    e_cg = cr && !e_vg;
    @(negedge sysclk);
    chk("cpu_gnt", 64'(bus.cpu_gnt), 64'(e_cg));
    chk("vga_gnt", 64'(bus.vga_gnt), 64'(e_vg));
    chk("mem_en", 64'(bus.mem_en), 64'(e_cg || e_vg));
    chk("mem_we", 64'(bus.mem_we), 64'(e_cg && bus.cpu_we));
    if (e_cg)
      chk("mem_addr", 64'(bus.mem_addr), 64'(bus.cpu_addr));
    else if (e_vg)
      chk("mem_addr", 64'(bus.mem_addr), 64'(bus.vga_addr));
    if (e_cg && bus.cpu_we)
      chk("mem_wdata", 64'(bus.mem_wdata), 64'(bus.cpu_wdata));
    chk("cpu_rvalid", 64'(bus.cpu_rvalid), 64'(m_cpend));
    chk("cpu_rdata", 64'(bus.cpu_rdata),
        64'(m_cpend ? m_cdata : m_chold));
    chk("vga_rvalid", 64'(bus.vga_rvalid), 64'(m_vpend));
    chk("vga_rdata", 64'(bus.vga_rdata),
        64'(m_vpend ? m_vdata : m_vhold));
  endtask

  task automatic advance();
    @(posedge sysclk);
    if (m_cpend) m_chold = m_cdata;
    if (m_vpend) m_vhold = m_vdata;
    m_cpend = e_cg && !bus.cpu_we;
    m_vpend = e_vg;
    if (m_cpend) m_cdata = ref_mem[bus.cpu_addr];
    if (m_vpend) m_vdata = ref_mem[bus.vga_addr];
    if (e_cg && bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
    if (bus.vga_req && !e_vg)
      m_wait = (m_wait + 1 > MW) ? MW : m_wait + 1;
    else
      m_wait = 0;
    if (e_cg)      m_last_vga = 1'b0;
    else if (e_vg) m_last_vga = 1'b1;
    #1;
  endtask

  task automatic cyc(input bit cr, input bit cwe,
                     input logic [AW-1:0] ca,
                     input logic [DW-1:0] cd,
                     input bit vr,
                     input logic [AW-1:0] va);
    drive(cr, cwe, ca, cd, vr, va);
    eval_check();
    advance();
  endtask

  // Reset with requests asserted: every output must read zero
  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b1, 1'b1, 9'h005, 32'hFFFF_FFFF, 1'b1, 9'h006);
    @(negedge sysclk);
    chk("rst_cpu_gnt", 64'(bus.cpu_gnt), 64'd0);
    chk("rst_vga_gnt", 64'(bus.vga_gnt), 64'd0);
    chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd0);
    chk("rst_vga_rvalid", 64'(bus.vga_rvalid), 64'd0);
    chk("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
    chk("rst_vga_rdata", 64'(bus.vga_rdata), 64'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    @(posedge sysclk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
    model_reset();
    //      cr cwe ca      cd            vr va
    //      ecg evg ecv ecd             evv evd
    tbl[0] = '{0, 0, 9'h000, 32'h0, 0, 9'h000,
               0, 0, 0, 32'h0, 0, 32'h0};
    tbl[1] = '{1, 0, 9'h010, 32'h0, 0, 9'h000,
               1, 0, 0, 32'h0, 0, 32'h0};
    tbl[2] = '{1, 1, 9'h041, 32'hA5A5_A5A5, 0, 9'h000,
               1, 0, 1, 32'h1234_5678, 0, 32'h0};
    tbl[3] = '{0, 0, 9'h000, 32'h0, 1, 9'h041,
               0, 1, 0, 32'h1234_5678, 0, 32'h0};
    tbl[4] = '{0, 0, 9'h000, 32'h0, 0, 9'h000,
               0, 0, 0, 32'h1234_5678, 1, 32'hA5A5_A5A5};

    do_reset();
    do_reset();

    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].cr, tbl[i].cwe, tbl[i].ca, tbl[i].cd,
            tbl[i].vr, tbl[i].va);
      eval_check();
      chk($sformatf("tbl%0d_cpu_gnt", i),
          64'(bus.cpu_gnt), 64'(tbl[i].ecg));
      chk($sformatf("tbl%0d_vga_gnt", i),
          64'(bus.vga_gnt), 64'(tbl[i].evg));
      chk($sformatf("tbl%0d_cpu_rvalid", i),
          64'(bus.cpu_rvalid), 64'(tbl[i].ecv));
      chk($sformatf("tbl%0d_cpu_rdata", i),
          64'(bus.cpu_rdata), 64'(tbl[i].ecd));
      chk($sformatf("tbl%0d_vga_rvalid", i),
          64'(bus.vga_rvalid), 64'(tbl[i].evv));
      chk($sformatf("tbl%0d_vga_rdata", i),
          64'(bus.vga_rdata), 64'(tbl[i].evd));
      if (tbl[i].cr && tbl[i].cwe)
        chk($sformatf("tbl%0d_mem_addr", i),
            64'(bus.mem_addr), 64'(tbl[i].ca));
      advance();
    end

    // Continuous conflict from a fresh reset
    do_reset();
    for (int k = 0; k < 15; k++) begin
      bit exp_v;
`ifdef MEM_ARBITER_RR_EN
      exp_v = (k % 2) == 1;
`else
      exp_v = (k % (MW + 1)) == MW;
`endif
      drive(1'b1, 1'b0, AW'(k), '0, 1'b1, AW'(k + 100));
      eval_check();
      chk($sformatf("policy%0d_vga_gnt", k),
          64'(bus.vga_gnt), 64'(exp_v));
      chk($sformatf("policy%0d_cpu_gnt", k),
          64'(bus.cpu_gnt), 64'(!exp_v));
      advance();
    end

    // Randomized traffic, small address window for read-after-write
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          AW'($urandom_range(0, 31)), DW'($urandom),
          1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)));
    end

    // Reset the cycle after a VGA read grant cancels its rvalid
    cyc(1'b0, 1'b0, '0, '0, 1'b0, '0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 9'h020);
    eval_check();
    chk("pre_rst_vga_gnt", 64'(bus.vga_gnt), 64'd1);
    advance();
    do_reset();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    eval_check();
    chk("post_rst_vga_rvalid", 64'(bus.vga_rvalid), 64'd0);
    chk("post_rst_mem_en", 64'(bus.mem_en), 64'd0);
    advance();
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 9'h010);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
